bmp_loader: RTL and testbench

Streaming BMP decoder between `data_io` and the SDRAM upload port of the menu core. It parses the BMP header from the ioctl byte stream, validates it, and strips row padding. It writes each pixel as a 32-bit little-endian word into a fixed-stride framebuffer through a toggle req/ack port. It generalises the menu's fixed 640-wide 32-bpp loader to 24/32-bpp sources, any image size up to the framebuffer, bottom-up or top-down images, and a programmable base address.

---
 rtl/bmp_loader_pkg.sv | 30 +++
 rtl/word_fifo.sv | 57 +++++
 rtl/bmp_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_bmp_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_loader_pkg.sv
// rtl/bmp_loader_pkg.sv - shared states, BMP header offsets and helpers for bmp_loader
package bmp_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SKIP,
        ST_PIXEL,
        ST_PAD,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int OFF_SIG_LO   = 0;
    localparam int OFF_SIG_HI   = 1;
    localparam int OFF_DATA     = 10;
    localparam int OFF_WIDTH    = 18;
    localparam int OFF_HEIGHT   = 22;
    localparam int OFF_BPP      = 28;
    localparam int OFF_COMP     = 30;
    localparam int OFF_LAST     = 33;
    localparam int MIN_DATA_OFF = 34;

    localparam logic [15:0] BMP_SIG = 16'h4D42;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - small synchronous FIFO with full/empty flags; pushes while full are dropped
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/bmp_loader.sv
// rtl/bmp_loader.sv - streaming 24/32-bpp BMP to framebuffer loader; BMP_LOADER_CLIP_EN clips oversized images
module bmp_loader
    import bmp_loader_pkg::*;
#(
    parameter int FB_W       = 640,
    parameter int FB_H       = 312,
    parameter int FB_BASE    = 0,
    parameter int AW         = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          port_req,
    input  logic          port_ack,
    output logic [AW-2:0] port_a,
    output logic [1:0]    port_ds,
    output logic [15:0]   port_d,
    output logic          loaded,
    output logic          err,
    output logic [15:0]   img_w,
    output logic [15:0]   img_h
);

    localparam int FW = AW - 1 + 16;
    localparam logic [31:0] FB_BASE_W = 32'(FB_BASE) >> 1;

    state_t state, state_d;

    logic        dl_q;
    logic [7:0]  sig_lo;
    logic [31:0] data_off, hdr_w, hdr_h;
    logic [23:0] hdr_comp;
    logic [15:0] hdr_bpp;
    logic [15:0] x, r;
    logic [1:0]  bi, pad_cnt;
    logic [7:0]  b_byte, r_byte;
    logic [31:0] row_base;

    logic          dl_rise, dl_fall, abort;
    logic          bpp32, bottom_up;
    logic [31:0]   addr32, comp_full, h_abs, pix_idx;
    logic          size_ok, hdr_ok, in_fb;
    logic          wr_hdr, bad_sig, hdr_last, skip_hit;
    logic          wr_pix, pix_last, row_end, pad_last, last_row;
    logic [1:0]    last_bi, pad_n;
    logic [15:0]   y_cur;
    logic [AW-2:0] wa0, wa1;
    logic          push_lo, push_hi, push, overflow, issue;
    logic [FW-1:0] fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty;

    assign dl_rise   = ioctl_download && !dl_q;
    assign dl_fall   = !ioctl_download && dl_q;
    assign abort     = dl_fall && state != ST_IDLE && state != ST_DONE;
    assign bpp32     = (hdr_bpp == 16'd32);
    assign bottom_up = !hdr_h[31];
    assign addr32    = {7'd0, ioctl_addr};
    assign comp_full = {ioctl_dout, hdr_comp};
    assign h_abs     = abs32(hdr_h);

`ifdef BMP_LOADER_CLIP_EN
    assign size_ok = 1'b1;
    assign in_fb   = (32'(x) < 32'(FB_W)) && (32'(y_cur) < 32'(FB_H));
`else
    assign size_ok = (hdr_w <= 32'(FB_W)) && (h_abs <= 32'(FB_H));
    assign in_fb   = 1'b1;
`endif

    // Checked on the final header byte, so the compression MSB comes straight off the bus.
    assign hdr_ok = (hdr_bpp == 16'd24 || hdr_bpp == 16'd32) && comp_full == 32'd0
                 && hdr_w != 32'd0 && h_abs != 32'd0
                 && hdr_w[31:16] == 16'd0 && h_abs[31:16] == 16'd0
                 && data_off >= 32'(MIN_DATA_OFF) && size_ok;

    assign wr_hdr   = (state == ST_HEADER) && ioctl_wr;
    assign bad_sig  = wr_hdr && ioctl_addr == 25'(OFF_SIG_HI) && {ioctl_dout, sig_lo} != BMP_SIG;
    assign hdr_last = wr_hdr && ioctl_addr == 25'(OFF_LAST);
    assign skip_hit = (state == ST_SKIP) && ioctl_wr && addr32 == data_off - 32'd1;

    assign wr_pix   = (state == ST_PIXEL) && ioctl_wr;
    assign last_bi  = bpp32 ? 2'd3 : 2'd2;
    assign pix_last = wr_pix && bi == last_bi;
    assign row_end  = pix_last && (x + 16'd1 == img_w);
    // 24-bpp rows are 3*w bytes, so the pad to a 4-byte boundary is w mod 4.
    assign pad_n    = bpp32 ? 2'd0 : img_w[1:0];
    assign pad_last = (state == ST_PAD) && ioctl_wr && pad_cnt == 2'd1;
    assign last_row = (r + 16'd1 == img_h);

    assign y_cur   = bottom_up ? (img_h - 16'd1 - r) : r;
    assign pix_idx = row_base + 32'(x);
    assign wa0     = (AW-1)'(FB_BASE_W + (pix_idx << 1));
    assign wa1     = wa0 + 1'b1;

    assign push_lo  = wr_pix && bi == 2'd1 && in_fb;
    assign push_hi  = pix_last && in_fb;
    assign push     = push_lo || push_hi;
    assign fifo_din = push_lo ? {wa0, ioctl_dout, b_byte}
                              : {wa1, (bpp32 ? ioctl_dout : 8'h00), (bpp32 ? r_byte : ioctl_dout)};
    assign overflow = push && fifo_full;
    assign issue    = !fifo_empty && (port_req == port_ack);
    assign port_ds  = 2'b11;

    word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FW)) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .clr   (dl_rise),
        .push  (push),
        .din   (fifo_din),
        .pop   (issue),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (dl_rise) begin
            state_d = ST_HEADER;
        end else if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_HEADER: begin
                    if (bad_sig)
                        state_d = ST_ERROR;
                    else if (hdr_last)
                        state_d = !hdr_ok ? ST_ERROR
                                : (data_off == 32'(MIN_DATA_OFF) ? ST_PIXEL : ST_SKIP);
                end
                ST_SKIP:  if (skip_hit) state_d = ST_PIXEL;
                ST_PIXEL: if (row_end)  state_d = (pad_n != 2'd0) ? ST_PAD
                                                : (last_row ? ST_DONE : ST_PIXEL);
                ST_PAD:   if (pad_last) state_d = last_row ? ST_DONE : ST_PIXEL;
                default:  state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q     <= 1'b0;
            sig_lo   <= '0;
            data_off <= '0;
            hdr_w    <= '0;
            hdr_h    <= '0;
            hdr_comp <= '0;
            hdr_bpp  <= '0;
            x        <= '0;
            r        <= '0;
            bi       <= '0;
            pad_cnt  <= '0;
            b_byte   <= '0;
            r_byte   <= '0;
            row_base <= '0;
            img_w    <= '0;
            img_h    <= '0;
            loaded   <= 1'b0;
            err      <= 1'b0;
        end else begin
            dl_q     <= ioctl_download;
            row_base <= 32'(y_cur) * 32'(FB_W);
            if (dl_rise) begin
                sig_lo   <= '0;
                data_off <= '0;
                hdr_w    <= '0;
                hdr_h    <= '0;
                hdr_comp <= '0;
                hdr_bpp  <= '0;
                x        <= '0;
                r        <= '0;
                bi       <= '0;
                pad_cnt  <= '0;
                img_w    <= '0;
                img_h    <= '0;
                loaded   <= 1'b0;
                err      <= 1'b0;
            end else begin
                if (bad_sig || (hdr_last && !hdr_ok) || overflow || abort)
                    err <= 1'b1;
                if (wr_hdr) begin
                    if (ioctl_addr == 25'(OFF_SIG_LO)) sig_lo <= ioctl_dout;
                    for (int i = 0; i < 4; i++) begin
                        if (ioctl_addr == 25'(OFF_DATA + i))   data_off[8*i +: 8] <= ioctl_dout;
                        if (ioctl_addr == 25'(OFF_WIDTH + i))  hdr_w[8*i +: 8]    <= ioctl_dout;
                        if (ioctl_addr == 25'(OFF_HEIGHT + i)) hdr_h[8*i +: 8]    <= ioctl_dout;
                    end
                    for (int i = 0; i < 3; i++)
                        if (ioctl_addr == 25'(OFF_COMP + i)) hdr_comp[8*i +: 8] <= ioctl_dout;
                    for (int i = 0; i < 2; i++)
                        if (ioctl_addr == 25'(OFF_BPP + i)) hdr_bpp[8*i +: 8] <= ioctl_dout;
                end
                if (hdr_last) begin
                    img_w <= hdr_w[15:0];
                    img_h <= h_abs[15:0];
                end
                if (wr_pix) begin
                    if (bi == 2'd0) b_byte <= ioctl_dout;
                    if (bi == 2'd2) r_byte <= ioctl_dout;
                    bi <= pix_last ? 2'd0 : bi + 2'd1;
                end
                if (pix_last)                            x <= row_end ? 16'd0 : x + 16'd1;
                if (row_end)                             pad_cnt <= pad_n;
                if (state == ST_PAD && ioctl_wr)         pad_cnt <= pad_cnt - 2'd1;
                if ((row_end && pad_n == 2'd0) || pad_last) r <= r + 16'd1;
                if (state == ST_DONE && fifo_empty && port_req == port_ack)
                    loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            port_req <= 1'b0;
            port_a   <= '0;
            port_d   <= '0;
        end else if (issue) begin
            port_req <= ~port_req;
            port_a   <= fifo_dout[FW-1:16];
            port_d   <= fifo_dout[15:0];
        end
    end

endmodule

// File: tb/tb_bmp_loader.sv
// tb/tb_bmp_loader.sv - directed self-checking bench for bmp_loader
module tb_bmp_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port_req;
    logic        port_ack;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic        loaded;
    logic        err;
    logic [15:0] img_w;
    logic [15:0] img_h;

    int tests = 0;
    int fails = 0;
    logic stall = 1'b0;
    logic [22:0] wr_a [$];
    logic [15:0] wr_d [$];
    logic [7:0]  file_q [$];

    always #5 clk_sys = ~clk_sys;

    bmp_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .port_req       (port_req),
        .port_ack       (port_ack),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .loaded         (loaded),
        .err            (err),
        .img_w          (img_w),
        .img_h          (img_h)
    );

    // SDRAM model: acknowledges every outstanding request half a cycle later unless stalled.
    initial begin
        port_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                port_ack = 1'b0;
            end else if (!stall && port_req !== port_ack) begin
                wr_a.push_back(port_a);
                wr_d.push_back(port_d);
                port_ack = port_req;
            end
        end
    end

    task automatic build_hdr(input int w, input int h, input int bpp, input int off, input logic [7:0] s0);
        file_q.delete();
        for (int i = 0; i < off; i++) file_q.push_back(8'h00);
        file_q[0] = s0;
        file_q[1] = 8'h4D;
        for (int i = 0; i < 4; i++) begin
            file_q[10+i] = 8'(off >> (8*i));
            file_q[18+i] = 8'(w >> (8*i));
            file_q[22+i] = 8'(h >> (8*i));
        end
        file_q[28] = 8'(bpp);
        file_q[29] = 8'(bpp >> 8);
    endtask

    task automatic make_2x2();
        logic [7:0] px [16];
        build_hdr(2, 2, 24, 54, 8'h42);
        px = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hEE, 8'hEE,
               8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hEE, 8'hEE};
        for (int i = 0; i < 16; i++) file_q.push_back(px[i]);
    endtask

    task automatic send_file(input int nbytes);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < nbytes; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = file_q[i];
            ioctl_wr   = 1'b1;
            @(negedge clk_sys);
            ioctl_wr   = 1'b0;
            @(negedge clk_sys);
        end
    endtask

    task automatic end_download();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic wait_loaded(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_sys);
            if (loaded) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({port_req, port_a, port_d, port_ds} !== {1'b0, 23'd0, 16'd0, 2'b11}) begin
            fails++;
            $display("FAIL reset_port: got %0h expected %0h", {port_req, port_a, port_d, port_ds}, 3);
        end
        tests++;
        if ({loaded, err, img_w, img_h} !== 34'd0) begin
            fails++;
            $display("FAIL reset_status: got %0h expected 0", {loaded, err, img_w, img_h});
        end
    endtask

    task automatic test_bottom_up_24();
        logic [22:0] ea [8];
        logic [15:0] ed [8];
        logic [38:0] got;
        bit ok;
        ea = '{23'd1280, 23'd1281, 23'd1282, 23'd1283, 23'd0, 23'd1, 23'd2, 23'd3};
        ed = '{16'h0201, 16'h0003, 16'h0504, 16'h0006, 16'h0807, 16'h0009, 16'h0B0A, 16'h000C};
        wr_a.delete(); wr_d.delete();
        make_2x2();
        send_file(file_q.size());
        wait_loaded(200, ok);
        end_download();
        tests++;
        if (ok !== 1'b1 || loaded !== 1'b1) begin
            fails++;
            $display("FAIL bu24_loaded: got %0b expected 1", loaded);
        end
        tests++;
        if (wr_a.size() !== 8) begin
            fails++;
            $display("FAIL bu24_count: got %0d expected 8", wr_a.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < wr_a.size()) ? {wr_a[i], wr_d[i]} : '1;
            tests++;
            if (got !== {ea[i], ed[i]}) begin
                fails++;
                $display("FAIL bu24_word%0d: got %0h expected %0h", i, got, {ea[i], ed[i]});
            end
        end
        tests++;
        if ({err, img_w, img_h} !== {1'b0, 16'd2, 16'd2}) begin
            fails++;
            $display("FAIL bu24_status: got %0h expected %0h", {err, img_w, img_h}, {1'b0, 16'd2, 16'd2});
        end
    endtask

    task automatic test_top_down_32();
        logic [7:0]  px [12];
        logic [15:0] ed [6];
        logic [38:0] got;
        bit ok;
        px = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        ed = '{16'h2211, 16'h4433, 16'h6655, 16'h8877, 16'hAA99, 16'hCCBB};
        wr_a.delete(); wr_d.delete();
        build_hdr(3, -1, 32, 54, 8'h42);
        for (int i = 0; i < 12; i++) file_q.push_back(px[i]);
        send_file(file_q.size());
        wait_loaded(200, ok);
        end_download();
        tests++;
        if (ok !== 1'b1 || wr_a.size() !== 6) begin
            fails++;
            $display("FAIL td32_done: got loaded=%0b count=%0d expected loaded=1 count=6", loaded, wr_a.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < wr_a.size()) ? {wr_a[i], wr_d[i]} : '1;
            tests++;
            if (got !== {23'(i), ed[i]}) begin
                fails++;
                $display("FAIL td32_word%0d: got %0h expected %0h", i, got, {23'(i), ed[i]});
            end
        end
        tests++;
        if ({err, img_w, img_h} !== {1'b0, 16'd3, 16'd1}) begin
            fails++;
            $display("FAIL td32_status: got %0h expected %0h", {err, img_w, img_h}, {1'b0, 16'd3, 16'd1});
        end
    endtask

    task automatic test_bad_header();
        int bpp_v [2];
        logic [7:0] s0_v [2];
        bpp_v = '{16, 24};
        s0_v  = '{8'h42, 8'h58};
        for (int k = 0; k < 2; k++) begin
            wr_a.delete(); wr_d.delete();
            build_hdr(2, 2, bpp_v[k], 54, s0_v[k]);
            for (int i = 0; i < 16; i++) file_q.push_back(8'(i + 1));
            send_file(file_q.size());
            repeat (20) @(negedge clk_sys);
            tests++;
            if ({err, loaded} !== 2'b10 || wr_a.size() !== 0) begin
                fails++;
                $display("FAIL bad_hdr%0d: got err=%0b loaded=%0b writes=%0d expected err=1 loaded=0 writes=0",
                         k, err, loaded, wr_a.size());
            end
            end_download();
        end
    endtask

    task automatic test_stall();
        logic [38:0] got;
        wr_a.delete(); wr_d.delete();
        stall = 1'b1;
        build_hdr(8, 1, 32, 54, 8'h42);
        for (int i = 0; i < 32; i++) file_q.push_back(8'(i));
        send_file(file_q.size());
        repeat (30) @(negedge clk_sys);
        tests++;
        if (err !== 1'b1 || wr_a.size() !== 0) begin
            fails++;
            $display("FAIL stall_overflow: got err=%0b writes=%0d expected err=1 writes=0", err, wr_a.size());
        end
        stall = 1'b0;
        repeat (40) @(negedge clk_sys);
        tests++;
        if (wr_a.size() !== 5) begin
            fails++;
            $display("FAIL stall_drain_count: got %0d expected 5", wr_a.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < wr_a.size()) ? {wr_a[i], wr_d[i]} : '1;
            tests++;
            if (got !== {23'(i), 8'(2*i+1), 8'(2*i)}) begin
                fails++;
                $display("FAIL stall_word%0d: got %0h expected %0h", i, got, {23'(i), 8'(2*i+1), 8'(2*i)});
            end
        end
        end_download();
    endtask

    task automatic test_wide();
        bit ok;
        wr_a.delete(); wr_d.delete();
        build_hdr(700, 1, 24, 54, 8'h42);
        for (int i = 0; i < 2100; i++) file_q.push_back(8'(i));
        send_file(file_q.size());
        wait_loaded(200, ok);
`ifdef BMP_LOADER_CLIP_EN
        tests++;
        if (ok !== 1'b1 || err !== 1'b0 || wr_a.size() !== 1280) begin
            fails++;
            $display("FAIL wide_clip: got loaded=%0b err=%0b writes=%0d expected 1 0 1280", loaded, err, wr_a.size());
        end
        tests++;
        if (wr_a.size() == 1280 && {wr_a[1279], wr_d[1279]} !== {23'd1279, 16'h007F}) begin
            fails++;
            $display("FAIL wide_clip_last: got %0h expected %0h", {wr_a[1279], wr_d[1279]}, {23'd1279, 16'h007F});
        end
`else
        tests++;
        if (err !== 1'b1 || loaded !== 1'b0 || wr_a.size() !== 0) begin
            fails++;
            $display("FAIL wide_reject: got err=%0b loaded=%0b writes=%0d expected 1 0 0", err, loaded, wr_a.size());
        end
`endif
        tests++;
        if (img_w !== 16'd700) begin
            fails++;
            $display("FAIL wide_img_w: got %0d expected 700", img_w);
        end
        end_download();
    endtask

    task automatic test_early_end();
        make_2x2();
        send_file(59);
        end_download();
        repeat (5) @(negedge clk_sys);
        tests++;
        if ({err, loaded} !== 2'b10) begin
            fails++;
            $display("FAIL early_end: got err=%0b loaded=%0b expected err=1 loaded=0", err, loaded);
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] ea [8];
        logic [15:0] ed [8];
        logic [38:0] got;
        bit ok;
        ea = '{23'd1280, 23'd1281, 23'd1282, 23'd1283, 23'd0, 23'd1, 23'd2, 23'd3};
        ed = '{16'h0201, 16'h0003, 16'h0504, 16'h0006, 16'h0807, 16'h0009, 16'h0B0A, 16'h000C};
        make_2x2();
        send_file(58);
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        tests++;
        if ({port_req, port_a, port_d, port_ds} !== {1'b0, 23'd0, 16'd0, 2'b11}) begin
            fails++;
            $display("FAIL midreset_port: got %0h expected %0h", {port_req, port_a, port_d, port_ds}, 3);
        end
        tests++;
        if ({loaded, err, img_w, img_h} !== 34'd0) begin
            fails++;
            $display("FAIL midreset_status: got %0h expected 0", {loaded, err, img_w, img_h});
        end
        reset = 1'b0;
        @(negedge clk_sys);
        wr_a.delete(); wr_d.delete();
        send_file(file_q.size());
        wait_loaded(200, ok);
        end_download();
        tests++;
        if (ok !== 1'b1 || err !== 1'b0 || wr_a.size() !== 8) begin
            fails++;
            $display("FAIL midreset_reload: got loaded=%0b err=%0b writes=%0d expected 1 0 8", loaded, err, wr_a.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < wr_a.size()) ? {wr_a[i], wr_d[i]} : '1;
            tests++;
            if (got !== {ea[i], ed[i]}) begin
                fails++;
                $display("FAIL midreset_word%0d: got %0h expected %0h", i, got, {ea[i], ed[i]});
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        test_bottom_up_24();
        test_top_down_32();
        test_bad_header();
        test_stall();
        test_wide();
        test_early_end();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
